// File: rtl/down_timer_pkg.sv
// Shared definitions for the reloadable down-counting timer.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Reloadable down timer with one-shot/periodic terminal-count pulse.
// Optional sticky interrupt (irq/irq_clr) enabled by DOWN_TIMER_IRQ_STICKY_EN.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             start,
    input  logic             stop,
`ifdef DOWN_TIMER_IRQ_STICKY_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] val,
    output logic             busy,
    output logic             tc
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] w_val_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_busy;
    logic             w_load_fire;

    assign load_ready  = (r_state != RUN);
    assign w_load_fire = load_valid & load_ready;

    // Next-state, next-count and terminal-count decode
    always_comb begin
        w_state_nxt  = r_state;
        w_val_nxt    = r_val;
        w_tc_nxt     = 1'b0;
        // A same-cycle load is what a same-cycle start must see
        w_reload_nxt = w_load_fire ? load_val : r_reload;
        case (r_state)
            IDLE, DONE: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_val_nxt   = {WIDTH{1'b0}};
                end else if (start && (w_reload_nxt != {WIDTH{1'b0}})) begin
                    w_state_nxt = RUN;
                    w_val_nxt   = w_reload_nxt;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = HOLD;
                end else if (cen && (r_val == WIDTH'(1))) begin
                    w_tc_nxt = 1'b1;
                    // A zero reload written during HOLD cannot run, so it ends the sequence
                    if (periodic && (r_reload != {WIDTH{1'b0}})) begin
                        w_val_nxt = r_reload;
                    end else begin
                        w_val_nxt   = {WIDTH{1'b0}};
                        w_state_nxt = DONE;
                    end
                end else if (cen) begin
                    w_val_nxt = r_val - WIDTH'(1);
                end else begin
                    w_val_nxt = r_val;
                end
            end
            HOLD: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_val_nxt   = {WIDTH{1'b0}};
                end else if (start) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_val_nxt   = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, count, reload and event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_val    <= {WIDTH{1'b0}};
            r_reload <= {WIDTH{1'b0}};
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_val    <= w_val_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
        end
    end

    assign val  = r_val;
    assign busy = r_busy;
    assign tc   = r_tc;

`ifdef DOWN_TIMER_IRQ_STICKY_EN
    logic r_irq;

    // Sticky interrupt: a tc pulse sets it and beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (r_tc) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq;
        end
    end

    assign irq = r_irq;
`endif

endmodule : down_timer
